// File: rtl/mult_div_unit.sv
// Iterative 32-bit multiply/divide unit with architectural HI/LO registers.
// One shift-add or restoring-divide step per clock, followed by a sign fix-up cycle.
module mult_div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        hi_we,
    input  logic        lo_we,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        is_div_q, is_div_d;
    logic        neg_res_q, neg_res_d;
    logic        neg_rem_q, neg_rem_d;
    logic [31:0] opnd_q, opnd_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic        is_signed;
    logic [31:0] rs_mag, rt_mag;
    logic [32:0] mul_sum;
    logic [32:0] div_shift;
    logic        div_ge;
    logic [31:0] div_sub;
    logic [63:0] prod_fix;
    logic [31:0] quot_fix, rem_fix;

    // opnd_q holds the multiplicand (multiply) or divisor (divide) magnitude.
    // acc_q is the 64-bit product accumulator, or {remainder, dividend/quotient} for divide.
    always_comb begin
        is_signed = ~op[0];
        rs_mag    = (is_signed && rs_data[31]) ? (~rs_data + 32'd1) : rs_data;
        rt_mag    = (is_signed && rt_data[31]) ? (~rt_data + 32'd1) : rt_data;

        mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);

        div_shift = {acc_q[63:32], acc_q[31]};
        div_ge    = (div_shift >= {1'b0, opnd_q});
        div_sub   = div_shift[31:0] - opnd_q;

        prod_fix  = neg_res_q ? (~acc_q + 64'd1) : acc_q;
        // A zero divisor leaves the all-ones quotient untouched.
        quot_fix  = (neg_res_q && (opnd_q != 32'd0)) ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
        rem_fix   = neg_rem_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        opnd_d    = opnd_q;
        acc_d     = acc_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = CALC;
                    cnt_d     = 5'd31;
                    busy_d    = 1'b1;
                    is_div_d  = op[1];
                    neg_res_d = is_signed & (rs_data[31] ^ rt_data[31]);
                    neg_rem_d = is_signed & rs_data[31] & op[1];
                    opnd_d    = op[1] ? rt_mag : rs_mag;
                    acc_d     = {32'd0, (op[1] ? rs_mag : rt_mag)};
                end else begin
                    if (hi_we) hi_d = rs_data;
                    if (lo_we) lo_d = rs_data;
                end
            end
            CALC: begin
                if (is_div_q) begin
                    acc_d = div_ge ? {div_sub, acc_q[30:0], 1'b1}
                                   : {div_shift[31:0], acc_q[30:0], 1'b0};
                end else begin
                    acc_d = {mul_sum, acc_q[31:1]};
                end
                if (cnt_q == 5'd0) begin
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            FIX: begin
                if (is_div_q) begin
                    hi_d = rem_fix;
                    lo_d = quot_fix;
                end else begin
                    hi_d = prod_fix[63:32];
                    lo_d = prod_fix[31:0];
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= 5'd0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            opnd_q    <= 32'd0;
            acc_q     <= 64'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            opnd_q    <= opnd_d;
            acc_q     <= acc_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed and random ops against an
// arithmetic reference model, plus MTHI/MTLO, busy-time interference and reset abort.
module tb_mult_div_unit;
    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        hi_we;
    logic        lo_we;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_total = 0;
    int n_pass  = 0;
    logic [31:0] exp_hi = 32'd0;
    logic [31:0] exp_lo = 32'd0;

    mult_div_unit dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .hi_we   (hi_we),
        .lo_we   (lo_we),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    endtask

    // Reference: plain signed/unsigned arithmetic; SV division truncates toward zero like MIPS.
    function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] h, output logic [31:0] l);
        longint      sa, sb, p;
        logic [63:0] pu;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            2'd0: begin p = sa * sb; h = p[63:32]; l = p[31:0]; end
            2'd1: begin pu = {32'd0, a} * {32'd0, b}; h = pu[63:32]; l = pu[31:0]; end
            2'd2: begin
                if (b == 32'd0) begin h = a; l = 32'hFFFFFFFF; end
                else begin p = sa % sb; h = p[31:0]; p = sa / sb; l = p[31:0]; end
            end
            default: begin
                if (b == 32'd0) begin h = a; l = 32'hFFFFFFFF; end
                else begin h = a % b; l = a / b; end
            end
        endcase
    endfunction

    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input bit noise, input bit with_we);
        logic [31:0] eh, el;
        int n_busy;
        int n_done;
        model(o, a, b, eh, el);
        @(negedge clk);
        op = o; rs_data = a; rt_data = b; start = 1'b1;
        hi_we = with_we; lo_we = with_we;
        @(negedge clk);
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        if (with_we) begin
            check({tag, "_we_dropped_hi"}, {32'd0, hi}, {32'd0, exp_hi});
            check({tag, "_we_dropped_lo"}, {32'd0, lo}, {32'd0, exp_lo});
        end
        n_busy = 0;
        n_done = 0;
        while (busy && n_busy < 100) begin
            n_busy++;
            if (done) n_done++;
            if (noise) begin
                rs_data = $urandom; rt_data = $urandom; op = 2'($urandom);
                start = 1'b1; hi_we = 1'b1; lo_we = 1'b1;
            end
            @(negedge clk);
        end
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        exp_hi = eh;
        exp_lo = el;
        check({tag, "_busy_cycles"}, 64'(n_busy), 64'd33);
        check({tag, "_done_in_busy"}, 64'(n_done), 64'd0);
        check({tag, "_done"}, {63'd0, done}, 64'd1);
        check({tag, "_hilo"}, {hi, lo}, {eh, el});
        $display("op=%0d rs=%h rt=%h -> hi=%h lo=%h (expect %h %h)", o, a, b, hi, lo, eh, el);
        @(negedge clk);
        check({tag, "_done_1cyc"}, {63'd0, done}, 64'd0);
        check({tag, "_hilo_hold"}, {hi, lo}, {eh, el});
    endtask

    initial begin
        int n_done;
        rst = 1'b1; start = 1'b0; op = 2'd0; rs_data = 32'd0; rt_data = 32'd0;
        hi_we = 1'b0; lo_we = 1'b0;
        #12;
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        check("reset_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op("multu_max", 2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0);
        check("multu_max_lit", {hi, lo}, {32'hFFFFFFFE, 32'h00000001});
        run_op("mult_neg", 2'd0, 32'hFFFFFFFD, 32'd7, 1'b0, 1'b0);
        check("mult_neg_lit", {hi, lo}, {32'hFFFFFFFF, 32'hFFFFFFEB});
        run_op("div_neg", 2'd2, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0);
        check("div_neg_lit", {hi, lo}, {32'hFFFFFFFF, 32'hFFFFFFFD});
        run_op("divu", 2'd3, 32'd100, 32'd7, 1'b0, 1'b0);
        run_op("divu_zero", 2'd3, 32'h12345678, 32'd0, 1'b0, 1'b0);
        run_op("div_zero_neg", 2'd2, 32'h87654321, 32'd0, 1'b0, 1'b0);
        run_op("div_ovf", 2'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0);
        check("div_ovf_lit", {hi, lo}, {32'h00000000, 32'h80000000});
        run_op("mult_busy_noise", 2'd0, 32'h7FFFFFFF, 32'h80000000, 1'b1, 1'b0);
        run_op("div_start_we", 2'd2, 32'd1000, 32'hFFFFFFFD, 1'b0, 1'b1);

        // MTLO, then MTHI+MTLO together
        @(negedge clk);
        rs_data = 32'hABCD0123; lo_we = 1'b1;
        @(negedge clk);
        lo_we = 1'b0;
        check("mtlo_lo", {32'd0, lo}, {32'd0, 32'hABCD0123});
        check("mtlo_hi_hold", {32'd0, hi}, {32'd0, exp_hi});
        exp_lo = 32'hABCD0123;
        rs_data = 32'h5A5AC3C3; hi_we = 1'b1; lo_we = 1'b1;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
        check("mthi_mtlo_both", {hi, lo}, {32'h5A5AC3C3, 32'h5A5AC3C3});
        exp_hi = 32'h5A5AC3C3; exp_lo = 32'h5A5AC3C3;

        for (int i = 0; i < 12; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            if (i % 4 == 3) b = b >> $urandom_range(0, 28);
            run_op($sformatf("rand%0d", i), 2'(i % 4), a, b, (i % 3) == 0, 1'b0);
        end

        // Reset in the middle of an operation
        @(negedge clk);
        op = 2'd1; rs_data = 32'hDEADBEEF; rt_data = 32'h01234567; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        n_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("abort_no_done", 64'(n_done), 64'd0);
        check("abort_hilo_after", {hi, lo}, 64'd0);
        check("abort_idle", {63'd0, busy}, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative multiply/divide unit with architectural HI/LO registers for the single-cycle MIPS datapath. It sits directly downstream of `reg_file` and takes `Read_Data_1` (rs) and `Read_Data_2` (rt) as operands for MULT, MULTU, DIV and DIVU. MTHI and MTLO write HI/LO directly. HI/LO feed the MFHI/MFLO writeback path. `busy` is used by control to stall PC update while an operation is in flight.

## Interface
- No parameters; data width fixed at 32.
- `clk` input 1: rising-edge clock shared with `reg_file`.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: launches the operation selected by `op`; sampled on a rising edge only while idle.
- `op` input 2: operation select. 00 = MULT, 01 = MULTU, 10 = DIV, 11 = DIVU.
- `rs_data` input 32: rs operand (multiplicand/dividend); also MTHI/MTLO write data.
- `rt_data` input 32: rt operand (multiplier/divisor).
- `hi_we` input 1: MTHI strobe, HI <= `rs_data`.
- `lo_we` input 1: MTLO strobe, LO <= `rs_data`.
- `busy` output 1: operation in progress.
- `done` output 1: one-cycle pulse; new HI/LO are visible.
- `hi` output 32: HI register.
- `lo` output 32: LO register.

## Operation
- State machine: IDLE, CALC, FIX.
- **IDLE**
  - `start`=1 latches `rs_data`, `rt_data` and `op`, then moves to CALC.
  - For signed ops, operands are latched as magnitudes, along with sign flags: result sign = sign(rs) XOR sign(rt); remainder sign = sign(rs).
  - Iteration counter loads 31.
- **CALC:** one iteration per clock; after the iteration with counter = 0, move to FIX.
  - Multiply: unsigned shift-add, 64-bit product accumulator.
  - Divide: unsigned restoring division, 32-bit quotient, 32-bit remainder.
- **FIX:** applies sign fix-up and writes HI/LO, sets `done`=1, returns to IDLE.
  - MULT/MULTU: {HI,LO} = 64-bit product, two's-complement negated if the result sign is set.
  - DIV/DIVU: LO = quotient, HI = remainder.
  - Signed divide: negate quotient if the result sign is set; negate remainder if the remainder sign is set.
- Divide by zero is deterministic and takes the full latency. Result: LO = 32'hFFFFFFFF, HI = `rs_data` as latched. For DIV, no sign fix-up is applied.
- DIV 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0. This is the natural result of the magnitude algorithm; no trap.
- `start` while busy is ignored.
- `hi_we`/`lo_we` while busy are ignored.
- `hi_we` and `lo_we` together in IDLE write both registers.
- `start` together with `hi_we`/`lo_we` in IDLE: `start` wins and the writes are dropped.
- `op` and operand changes after the start edge have no effect.

## Timing
- Reset (async, immediate): state IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0, counter=0.
- Reset mid-operation aborts it; no HI/LO update and no `done` pulse afterwards.
- Edge numbering for one operation:
  - Start sampled at edge E0; `busy`=1 from after E0.
  - Iterations at E1..E32.
  - FIX at E33: `hi`/`lo` updated and `done`=1 from after E33, `busy`=0 from after E33.
- `busy` is high for exactly 33 cycles; `done` is high for exactly 1 cycle.
- A new `start` is accepted at E33+1 at the earliest, i.e. in the cycle where `done`=1.
- MTHI/MTLO take effect at the sampling edge and are visible the next cycle.
- `hi` and `lo` hold their value at all times other than FIX, reset and MTHI/MTLO writes.
- `busy` and `done` are registered; no combinational path from any input.

## Test plan
- Reset, then MULTU with rs=0xFFFFFFFF, rt=0xFFFFFFFF -> after 33 busy cycles, `done` pulses once; HI=0xFFFFFFFE, LO=0x00000001.
- MULT with rs=0xFFFFFFFD (-3), rt=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB (-21).
- DIV with rs=0xFFFFFFF9 (-7), rt=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). DIVU with rs=100, rt=7 -> LO=14, HI=2.
- DIVU with rs=0x12345678, rt=0 -> LO=0xFFFFFFFF, HI=0x12345678.
- DIV with rs=0x80000000, rt=0xFFFFFFFF -> LO=0x80000000, HI=0.
- Boundary cases:
  - `start`, `hi_we` and new operands driven during busy -> no effect; result unchanged.
  - MTLO of 0xABCD0123 while idle -> `lo`=0xABCD0123 next cycle.
  - Assert `rst` at iteration 10 -> `busy`=0, HI=LO=0 immediately, no `done` pulse.
